// File: rtl/display_cfg_loader.sv
// Serialises a 75-bit timing-preset word to the display timing generator over cfg_clk/cfg_data,
// holding the generator disabled while it is reprogrammed and re-enabling it after a settle time.
module display_cfg_loader #(
  parameter int HALF   = 4,
  parameter int SETTLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       stop,
  input  logic [1:0] mode_sel,
  input  logic [5:0] pulse_count,
  input  logic       frame_pulse,
  output logic       cfg_clk,
  output logic       cfg_data,
  output logic       en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_FRAME, ST_SHIFT, ST_SETTLE} state_t;

  localparam logic [7:0] HALF_LAST   = 8'(HALF - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [6:0] BIT_LAST    = 7'd74;

  state_t      state_q, state_d;
  logic [74:0] word_q, word_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  phase_cnt_q, phase_cnt_d;
  logic        cfg_clk_q, cfg_clk_d;
  logic        cfg_data_q, cfg_data_d;
  logic        en_q, en_d;
  logic        done_q, done_d;

  function automatic logic [74:0] build_word(input logic [1:0] m, input logic [5:0] pc);
    logic [1:0]  pol;
    logic [10:0] hd, vd;
    logic [8:0]  hf, hs, hb;
    logic [5:0]  vb, vs, vt;
    case (m)
      2'd0:    begin pol = 2'b11; hd = 11'd639;  hf = 9'd15;  hs = 9'd95;  hb = 9'd47;
                     vd = 11'd479; vb = 6'd9; vs = 6'd1; vt = 6'd32; end
      2'd1:    begin pol = 2'b00; hd = 11'd799;  hf = 9'd39;  hs = 9'd127; hb = 9'd87;
                     vd = 11'd599; vb = 6'd0; vs = 6'd3; vt = 6'd22; end
      2'd2:    begin pol = 2'b11; hd = 11'd1023; hf = 9'd23;  hs = 9'd135; hb = 9'd159;
                     vd = 11'd767; vb = 6'd2; vs = 6'd5; vt = 6'd28; end
      default: begin pol = 2'b00; hd = 11'd1279; hf = 9'd109; hs = 9'd39;  hb = 9'd219;
                     vd = 11'd719; vb = 6'd4; vs = 6'd4; vt = 6'd19; end
    endcase
    return {pc, pol, hd, hf, hs, hb, vd, vb, vs, vt};
  endfunction

  logic bit_end;
  assign bit_end = (phase_cnt_q == HALF_LAST) && cfg_clk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      bit_cnt_q   <= '0;
      phase_cnt_q <= '0;
      cfg_clk_q   <= 1'b0;
      cfg_data_q  <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      cfg_clk_q   <= cfg_clk_d;
      cfg_data_q  <= cfg_data_d;
      en_q        <= en_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (load) state_d = en_q ? ST_WAIT_FRAME : ST_SHIFT;
      ST_WAIT_FRAME: if (frame_pulse || stop) state_d = ST_SHIFT;
      ST_SHIFT:      if (bit_end && bit_cnt_q == BIT_LAST) state_d = ST_SETTLE;
      ST_SETTLE:     if (phase_cnt_q == SETTLE_LAST) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_d      = word_q;
    bit_cnt_d   = bit_cnt_q;
    phase_cnt_d = phase_cnt_q;
    cfg_clk_d   = cfg_clk_q;
    cfg_data_d  = cfg_data_q;
    en_d        = en_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          word_d      = build_word(mode_sel, pulse_count);
          bit_cnt_d   = '0;
          phase_cnt_d = '0;
          cfg_clk_d   = 1'b0;
          // From a disabled generator the first bit goes out immediately.
          if (!en_q) cfg_data_d = word_d[74];
        end else if (stop) begin
          en_d = 1'b0;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_pulse || stop) begin
          en_d       = 1'b0;
          cfg_data_d = word_q[74];
        end
      end
      ST_SHIFT: begin
        if (phase_cnt_q != HALF_LAST) begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end else begin
          phase_cnt_d = '0;
          if (!cfg_clk_q) begin
            cfg_clk_d = 1'b1;
          end else begin
            cfg_clk_d = 1'b0;
            if (bit_cnt_q != BIT_LAST) begin
              bit_cnt_d  = bit_cnt_q + 7'd1;
              word_d     = {word_q[73:0], 1'b0};
              cfg_data_d = word_q[73];
            end
          end
        end
      end
      ST_SETTLE: begin
        if (phase_cnt_q == SETTLE_LAST) begin
          phase_cnt_d = '0;
          bit_cnt_d   = '0;
          en_d        = 1'b1;
          done_d      = 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign cfg_clk  = cfg_clk_q;
  assign cfg_data = cfg_data_q;
  assign en       = en_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_display_cfg_loader.sv
// Directed test of display_cfg_loader: word content, timing to en/done, frame wait, stop and reset abort.
module tb_display_cfg_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic [5:0] pulse_count = 6'd0;
  logic       frame_pulse = 1'b0;
  logic       cfg_clk, cfg_data, en, busy, done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int edges = 0;
  logic [74:0] cap = '0;

  display_cfg_loader #(.HALF(4), .SETTLE(8)) dut (
    .clk(clk), .rst(rst), .load(load), .stop(stop), .mode_sel(mode_sel),
    .pulse_count(pulse_count), .frame_pulse(frame_pulse), .cfg_clk(cfg_clk),
    .cfg_data(cfg_data), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: what the timing generator would latch.
  always @(posedge cfg_clk) begin
    edges = edges + 1;
    cap = {cap[73:0], cfg_data};
  end

  localparam logic [74:0] W0_PC5 = {6'd5,  2'b11, 11'd639,  9'd15,  9'd95,  9'd47,  11'd479, 6'd9, 6'd1, 6'd32};
  localparam logic [74:0] W0_PC1 = {6'd1,  2'b11, 11'd639,  9'd15,  9'd95,  9'd47,  11'd479, 6'd9, 6'd1, 6'd32};
  localparam logic [74:0] W1_PC7 = {6'd7,  2'b00, 11'd799,  9'd39,  9'd127, 9'd87,  11'd599, 6'd0, 6'd3, 6'd22};
  localparam logic [74:0] W2_PC0 = {6'd0,  2'b11, 11'd1023, 9'd23,  9'd135, 9'd159, 11'd767, 6'd2, 6'd5, 6'd28};
  localparam logic [74:0] W2_PC9 = {6'd9,  2'b11, 11'd1023, 9'd23,  9'd135, 9'd159, 11'd767, 6'd2, 6'd5, 6'd28};
  localparam logic [74:0] W3_PC63 = {6'd63, 2'b00, 11'd1279, 9'd109, 9'd39,  9'd219, 11'd719, 6'd4, 6'd4, 6'd19};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives load for exactly one cycle (T0), then scrambles the inputs to show they were captured.
  task automatic start_load(input logic [1:0] m, input logic [5:0] pc, output int t0);
    mode_sel = m;
    pulse_count = pc;
    load = 1'b1;
    t0 = cyc;
    step();
    load = 1'b0;
    mode_sel = ~m;
    pulse_count = ~pc;
  endtask

  task automatic wait_en(input int t0, output int lat);
    lat = -1;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (en) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    int t0, lat, e0, k;

    step();
    step();
    check("reset_cfg_clk", 75'(cfg_clk), 75'd0);
    check("reset_cfg_data", 75'(cfg_data), 75'd0);
    check("reset_en", 75'(en), 75'd0);
    check("reset_busy", 75'(busy), 75'd0);
    check("reset_done", 75'(done), 75'd0);
    rst = 1'b0;
    step();

    // Load from en=0: immediate shift, en/done at T0+609.
    e0 = edges;
    start_load(2'd0, 6'd5, t0);
    check("t1_busy", 75'(busy), 75'd1);
    check("t1_en_low", 75'(en), 75'd0);
    check("t1_first_bit", 75'(cfg_data), 75'(W0_PC5[74]));
    wait_en(t0, lat);
    check("t1_latency", 75'(lat), 75'd609);
    check("t1_done", 75'(done), 75'd1);
    check("t1_edges", 75'(edges - e0), 75'd75);
    check("t1_word", cap, W0_PC5);
    step();
    check("t1_done_pulse", 75'(done), 75'd0);
    check("t1_busy_idle", 75'(busy), 75'd0);

    // Load from en=1 waits for frame_pulse.
    e0 = edges;
    start_load(2'd2, 6'd0, t0);
    check("t2a_busy", 75'(busy), 75'd1);
    check("t2a_en_held", 75'(en), 75'd1);
    repeat (3) step();
    frame_pulse = 1'b1;
    step();
    frame_pulse = 1'b0;
    check("t2a_en_drop", 75'(en), 75'd0);
    wait_en(t0, lat);
    check("t2a_word", cap, W2_PC0);
    check("t2a_edges", 75'(edges - e0), 75'd75);

    e0 = edges;
    start_load(2'd1, 6'd7, t0);
    repeat (99) step();
    check("t2b_en_wait", 75'(en), 75'd1);
    check("t2b_no_edges", 75'(edges - e0), 75'd0);
    frame_pulse = 1'b1;
    step();
    frame_pulse = 1'b0;
    check("t2b_en_drop", 75'(en), 75'd0);
    check("t2b_busy", 75'(busy), 75'd1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (cfg_clk) begin
        k = i;
        break;
      end
    end
    check("t2b_first_rise", 75'(k), 75'd4);
    wait_en(t0, lat);
    check("t2b_word", cap, W1_PC7);
    check("t2b_edges", 75'(edges - e0), 75'd75);

    // Stop in IDLE with en=1.
    e0 = edges;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t3_en_off", 75'(en), 75'd0);
    check("t3_busy", 75'(busy), 75'd0);
    check("t3_cfg_clk", 75'(cfg_clk), 75'd0);
    step();
    step();
    check("t3_no_edges", 75'(edges - e0), 75'd0);

    // Load and stop during SHIFT are ignored.
    e0 = edges;
    start_load(2'd3, 6'd63, t0);
    repeat (50) step();
    load = 1'b1;
    stop = 1'b1;
    mode_sel = 2'd0;
    repeat (20) step();
    load = 1'b0;
    stop = 1'b0;
    wait_en(t0, lat);
    check("t4_latency", 75'(lat), 75'd609);
    check("t4_edges", 75'(edges - e0), 75'd75);
    check("t4_word", cap, W3_PC63);
    check("t4_done", 75'(done), 75'd1);

    // Stop in WAIT_FRAME.
    e0 = edges;
    start_load(2'd0, 6'd1, t0);
    repeat (5) step();
    check("t5_wait_en", 75'(en), 75'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t5_en_drop", 75'(en), 75'd0);
    wait_en(t0, lat);
    check("t5_word", cap, W0_PC1);
    check("t5_edges", 75'(edges - e0), 75'd75);

    // Reset mid-shift at bit 30, then full reload.
    stop = 1'b1;
    step();
    stop = 1'b0;
    e0 = edges;
    start_load(2'd1, 6'd7, t0);
    for (int i = 0; i < 1000; i++) begin
      if (edges - e0 >= 30) break;
      step();
    end
    check("t6_reached_bit30", 75'(edges - e0), 75'd30);
    #2 rst = 1'b1;
    #1;
    check("t6_async_outputs", 75'({cfg_clk, cfg_data, en, busy, done}), 75'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    e0 = edges;
    start_load(2'd2, 6'd9, t0);
    wait_en(t0, lat);
    check("t6_latency", 75'(lat), 75'd609);
    check("t6_edges", 75'(edges - e0), 75'd75);
    check("t6_word", cap, W2_PC9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
